// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: pointer/address width functions and default geometry.
package fifo_pkg;

  localparam int unsigned DefaultDepth = 16;
  localparam int unsigned DefaultWidth = 32;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = 1; v < n; v = v << 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  // One extra wrap bit above the address so full and empty are distinguishable.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous (show-ahead) read.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int unsigned nrOfEntries = DefaultDepth,
  parameter int unsigned bitWidth    = DefaultWidth
) (
  input  logic                            clock,
  input  logic                            wr_en_i,
  input  logic [clog2(nrOfEntries)-1:0]   wr_addr_i,
  input  logic [bitWidth-1:0]             wr_data_i,
  input  logic [clog2(nrOfEntries)-1:0]   rd_addr_i,
  output logic [bitWidth-1:0]             rd_data_o
);

  logic [bitWidth-1:0] mem_q [nrOfEntries];

  always_ff @(posedge clock) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/fifo_flags.sv
// Show-ahead synchronous FIFO with full/empty, occupancy and programmable thresholds.
// Define FIFO_ERROR_FLAGS_EN to add sticky overflow/underflow outputs.
module fifo_flags
  import fifo_pkg::*;
#(
  parameter int unsigned nrOfEntries      = DefaultDepth,
  parameter int unsigned bitWidth         = DefaultWidth,
  parameter int unsigned almostFullLevel  = 12,
  parameter int unsigned almostEmptyLevel = 4
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                push,
  input  logic [bitWidth-1:0]                 pushData,
  input  logic                                pop,
  output logic [bitWidth-1:0]                 popData,
  output logic                                full,
  output logic                                empty,
  output logic                                almostFull,
  output logic                                almostEmpty,
  output logic [ptr_width(nrOfEntries)-1:0]   fillLevel
`ifdef FIFO_ERROR_FLAGS_EN
  ,
  output logic                                overflow,
  output logic                                underflow
`endif
);

  localparam int unsigned PtrW  = ptr_width(nrOfEntries);
  localparam int unsigned AddrW = PtrW - 1;

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] fill_c;
  logic            addr_eq_c, wrap_eq_c;
  logic            full_c, empty_c;
  logic            push_acc_c, pop_acc_c;

  // Status decode from the registered pointers only.
  assign addr_eq_c = (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign wrap_eq_c = (wr_ptr_q[PtrW-1] == rd_ptr_q[PtrW-1]);
  assign full_c    = addr_eq_c & ~wrap_eq_c;
  assign empty_c   = addr_eq_c & wrap_eq_c;
  assign fill_c    = wr_ptr_q - rd_ptr_q;

  // A pop frees a slot in the same cycle, so push-on-full is allowed alongside it.
  assign pop_acc_c  = pop & ~empty_c;
  assign push_acc_c = push & (~full_c | pop_acc_c);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_acc_c) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop_acc_c) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  fifo_ram #(
    .nrOfEntries (nrOfEntries),
    .bitWidth    (bitWidth)
  ) u_ram (
    .clock     (clock),
    .wr_en_i   (push_acc_c),
    .wr_addr_i (wr_ptr_q[AddrW-1:0]),
    .wr_data_i (pushData),
    .rd_addr_i (rd_ptr_q[AddrW-1:0]),
    .rd_data_o (popData)
  );

  assign full        = full_c;
  assign empty       = empty_c;
  assign fillLevel   = fill_c;
  assign almostFull  = (fill_c >= PtrW'(almostFullLevel));
  assign almostEmpty = (fill_c <= PtrW'(almostEmptyLevel));

`ifdef FIFO_ERROR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // Sticky error capture; only reset clears them.
  always_comb begin
    overflow_d  = overflow_q | (push & full_c & ~pop);
    underflow_d = underflow_q | (pop & empty_c);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_fifo_flags.sv
// Directed table-driven bench for fifo_flags at default geometry (16 x 32, AF=12, AE=4).
module tb_fifo_flags;

  localparam int unsigned Depth = 16;
  localparam int unsigned AfLvl = 12;
  localparam int unsigned AeLvl = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        push;
  logic        pop;
  logic [31:0] pushData;
  logic [31:0] popData;
  logic        full;
  logic        empty;
  logic        almostFull;
  logic        almostEmpty;
  logic [4:0]  fillLevel;
`ifdef FIFO_ERROR_FLAGS_EN
  logic        overflow;
  logic        underflow;
`endif

  always #5 clock = ~clock;

  fifo_flags #(
    .nrOfEntries      (Depth),
    .bitWidth         (32),
    .almostFullLevel  (AfLvl),
    .almostEmptyLevel (AeLvl)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .push        (push),
    .pushData    (pushData),
    .pop         (pop),
    .popData     (popData),
    .full        (full),
    .empty       (empty),
    .almostFull  (almostFull),
    .almostEmpty (almostEmpty),
    .fillLevel   (fillLevel)
`ifdef FIFO_ERROR_FLAGS_EN
    ,
    .overflow    (overflow),
    .underflow   (underflow)
`endif
  );

  typedef struct {
    logic        rst;
    logic        psh;
    logic        pp;
    logic [31:0] din;
    int unsigned fill;
    logic        chk_head;
    logic [31:0] head;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  function automatic void add(input logic rst, input logic psh, input logic pp,
                              input logic [31:0] din, input int unsigned fill,
                              input logic chk_head, input logic [31:0] head);
    vec_t v;
    v.rst      = rst;
    v.psh      = psh;
    v.pp       = pp;
    v.din      = din;
    v.fill     = fill;
    v.chk_head = chk_head;
    v.head     = head;
    vecs.push_back(v);
  endfunction

  task automatic check(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d actual=0x%0h expected=0x%0h", nm, idx, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
  task automatic drive(input logic rst, input logic psh, input logic pp,
                       input logic [31:0] din);
    @(negedge clock);
    reset    = rst;
    push     = psh;
    pop      = pp;
    pushData = din;
    @(posedge clock);
    #1;
  endtask

  task automatic check_state(input int idx, input int unsigned fill,
                             input logic chk_head, input logic [31:0] head);
    check("fillLevel",   idx, 32'(fillLevel),   fill);
    check("full",        idx, 32'(full),        32'(fill == Depth));
    check("empty",       idx, 32'(empty),       32'(fill == 0));
    check("almostFull",  idx, 32'(almostFull),  32'(fill >= AfLvl));
    check("almostEmpty", idx, 32'(almostEmpty), 32'(fill <= AeLvl));
    if (chk_head) begin
      check("popData", idx, popData, head);
    end
  endtask

  initial begin
    reset    = 1'b1;
    push     = 1'b0;
    pop      = 1'b0;
    pushData = '0;

    add(1'b1, 1'b0, 1'b0, 32'h0, 0, 1'b0, 32'h0);
    // Fill with A0..AF, then a dropped push of FF on full.
    for (int i = 0; i < 16; i++) add(1'b0, 1'b1, 1'b0, 32'hA0 + 32'(i), 32'(i + 1), 1'b1, 32'hA0);
    add(1'b0, 1'b1, 1'b0, 32'hFF, 16, 1'b1, 32'hA0);
    // Drain: head walks A1..AF, then empty; an extra pop changes nothing.
    for (int k = 1; k <= 16; k++) add(1'b0, 1'b0, 1'b1, 32'h0, 32'(16 - k), k < 16, 32'hA0 + 32'(k));
    add(1'b0, 1'b0, 1'b1, 32'h0, 0, 1'b0, 32'h0);
    // Refill, then push BB with pop while full.
    for (int i = 0; i < 16; i++) add(1'b0, 1'b1, 1'b0, 32'hA0 + 32'(i), 32'(i + 1), 1'b1, 32'hA0);
    add(1'b0, 1'b1, 1'b1, 32'hBB, 16, 1'b1, 32'hA1);
    for (int j = 1; j <= 15; j++)
      add(1'b0, 1'b0, 1'b1, 32'h0, 32'(16 - j), 1'b1, (j <= 14) ? 32'hA1 + 32'(j) : 32'hBB);
    add(1'b0, 1'b0, 1'b1, 32'h0, 0, 1'b0, 32'h0);
    // Push and pop while empty: only the push lands.
    add(1'b0, 1'b1, 1'b1, 32'h55, 1, 1'b1, 32'h55);
    add(1'b0, 1'b0, 1'b1, 32'h0, 0, 1'b0, 32'h0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].psh, vecs[i].pp, vecs[i].din);
      check_state(i, vecs[i].fill, vecs[i].chk_head, vecs[i].head);
    end

    // Streaming at depth 3 across several pointer wraps.
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    check_state(1000, 0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 32'h100 + 32'(i));
    check_state(1001, 3, 1'b1, 32'h100);
    for (int k = 0; k < 40; k++) begin
      drive(1'b0, 1'b1, 1'b1, 32'h103 + 32'(k));
      check_state(1100 + k, 3, 1'b1, 32'h101 + 32'(k));
    end

    // Reset wins over a simultaneous push; the next push is the new head.
    drive(1'b1, 1'b1, 1'b0, 32'h99);
    check_state(1200, 0, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 32'h77);
    check_state(1201, 1, 1'b1, 32'h77);
    drive(1'b0, 1'b1, 1'b0, 32'h78);
    drive(1'b0, 1'b0, 1'b1, 32'h0);
    check_state(1202, 1, 1'b1, 32'h78);

`ifdef FIFO_ERROR_FLAGS_EN
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    check("overflow_rst",  1300, 32'(overflow),  32'h0);
    check("underflow_rst", 1300, 32'(underflow), 32'h0);
    drive(1'b0, 1'b0, 1'b1, 32'h0);
    check("underflow_set", 1301, 32'(underflow), 32'h1);
    check("overflow_idle", 1301, 32'(overflow),  32'h0);
    for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, 1'b0, 32'(i));
    check("overflow_fill", 1302, 32'(overflow),  32'h0);
    drive(1'b0, 1'b1, 1'b0, 32'hEE);
    check("overflow_set",  1303, 32'(overflow),  32'h1);
    drive(1'b0, 1'b1, 1'b1, 32'hEF);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    check("overflow_hold",  1304, 32'(overflow),  32'h1);
    check("underflow_hold", 1304, 32'(underflow), 32'h1);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    check("overflow_clr",  1305, 32'(overflow),  32'h0);
    check("underflow_clr", 1305, 32'(underflow), 32'h0);
`endif

    @(negedge clock);
    reset = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
